// File: rtl/tb_mem_pkg.sv
// Shared types and constants for the Avalon RAM model.
package tb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = 8;

endpackage

// File: rtl/avalon_ram_model_if.sv
// Avalon-MM bus bundle between a CPU master and the RAM model.
interface avalon_ram_model_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/avalon_ram_model_ram_word_array.sv
// Word storage with per-byte bus writes and a full-word preload port.
module ram_word_array
    import tb_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] byte_we,
    input  logic [AW-1:0]         wr_idx,
    input  logic [31:0]           wr_data,
    input  logic                  load_en,
    input  logic [AW-1:0]         load_idx,
    input  logic [31:0]           load_data,
    input  logic [AW-1:0]         rd_idx,
    output logic [31:0]           rd_word
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rd_word = mem[rd_idx];

    // Preload is assigned last so it overrides a bus write to the same word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_we[i]) begin
                mem[wr_idx][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
        end
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

endmodule

// File: rtl/avalon_ram_model.sv
// Avalon-MM slave RAM with wait states, preload port and sticky error flag.
module avalon_ram_model
    import tb_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter int          LOAD_AW     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    avalon_ram_model_if.slave  bus,
    input  logic               load_en,
    input  logic [LOAD_AW-1:0] load_idx,
    input  logic [31:0]        load_data,
    output logic               err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t          state;
    state_t          state_d;
    logic [3:0]      cnt;
    logic [3:0]      cnt_d;
    logic            latch;
    logic            ld_rd;
    logic            err_set;

    logic [AW-1:0]   lat_idx;
    logic            lat_wr;
    logic            lat_bad;
    logic [31:0]     lat_data;
    logic [3:0]      lat_be;
    logic [31:0]     rdata;

    logic            req;
    logic [31:0]     offset;
    logic            bad;
    logic [3:0]      byte_we;
    logic [31:0]     rd_word;

    assign req    = bus.read | bus.write;
    assign offset = bus.address - BASE_ADDR;

    // BASE_ADDR is word aligned, so offset[1:0] mirrors address[1:0].
    assign bad = (bus.address < BASE_ADDR)
              || ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS))
              || (offset[1:0] != 2'b00);

    assign bus.waitrequest = req && (state != ACK);
    assign bus.readdata    = rdata;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        latch   = 1'b0;
        ld_rd   = 1'b0;
        err_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    latch   = 1'b1;
                    err_set = bad | (bus.read & bus.write);
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end else if (cnt == 4'd0) begin
                    state_d = ACK;
                    ld_rd   = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata    <= 32'd0;
            err      <= 1'b0;
            lat_idx  <= '0;
            lat_wr   <= 1'b0;
            lat_bad  <= 1'b0;
            lat_data <= 32'd0;
            lat_be   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            err   <= err | err_set;
            if (latch) begin
                lat_idx  <= offset[AW+1:2];
                lat_wr   <= bus.write & ~bus.read;
                lat_bad  <= bad;
                lat_data <= bus.writedata;
                lat_be   <= bus.byteenable;
            end
            if (ld_rd) begin
                rdata <= lat_bad ? 32'd0 : rd_word;
            end
        end
    end

    assign byte_we = (state == ACK && lat_wr && !lat_bad) ? lat_be : 4'd0;

    ram_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk       (clk),
        .byte_we   (byte_we),
        .wr_idx    (lat_idx),
        .wr_data   (lat_data),
        .load_en   (load_en),
        .load_idx  (AW'(load_idx)),
        .load_data (load_data),
        .rd_idx    (lat_idx),
        .rd_word   (rd_word)
    );

endmodule

// File: tb/tb_avalon_ram_model.sv
// Scoreboard bench for avalon_ram_model against a word-array reference.
module tb_avalon_ram_model;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam int          W     = 2;
    localparam int          LAW   = 8;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            load_en = 1'b0;
    logic [LAW-1:0]  load_idx = '0;
    logic [31:0]     load_data = '0;
    logic            err;

    avalon_ram_model_if bus();

    avalon_ram_model #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W),
        .LOAD_AW     (LAW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          hi = 0;
    logic [31:0] mem_m [DEPTH];
    bit          err_m = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a < BASE) || ((off >> 2) >= 32'(DEPTH)) || (off % 4 != 0);
    endfunction

    // Monitor: every acknowledged transfer pops one expectation.
    always @(negedge clk) begin
        if (!reset_n) begin
            hi = 0;
        end else if (bus.read | bus.write) begin
            if (bus.waitrequest) begin
                hi++;
            end else begin
                check("latency", 32'(hi), 32'(W + 1));
                hi = 0;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack at %0t", $time);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.is_rd) check("readdata", bus.readdata, mon_e.data);
                    check("err_ack", {31'd0, err}, {31'd0, mon_e.err});
                end
            end
        end else begin
            hi = 0;
        end
    end

    task automatic load(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        load_en   = 1'b1;
        load_idx  = LAW'(idx);
        load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        mem_m[idx % DEPTH] = d;
    endtask

    task automatic xfer(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input bit scr, input bit col, input int cidx,
                        input logic [31:0] cdat);
        exp_t e;
        int   idx;
        int   n;
        bit   b;
        b     = addr_bad(a);
        idx   = int'((a - BASE) >> 2);
        e.is_rd = r;
        e.data  = (r && !b) ? mem_m[idx] : 32'd0;
        if (w && !r && !b) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_m[idx][i*8 +: 8] = d[i*8 +: 8];
        end
        if (col) mem_m[cidx % DEPTH] = cdat;
        err_m = err_m | b | (r & w);
        e.err = err_m;
        q.push_back(e);
        @(posedge clk); #1;
        bus.read       = r;
        bus.write      = w;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.waitrequest) break;
            n++;
            if (n > 40) begin
                total++;
                bad++;
                $display("FAIL ack_timeout addr %h", a);
                break;
            end
            if (scr && n >= 2) begin
                #1;
                bus.address    = $urandom;
                bus.writedata  = $urandom;
                bus.byteenable = 4'($urandom);
            end
        end
        if (col) begin
            #1;
            load_en   = 1'b1;
            load_idx  = LAW'(cidx);
            load_data = cdat;
        end
        @(posedge clk); #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        load_en   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(1'b1, 1'b0, a, 32'd0, 4'd0, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        xfer(1'b0, 1'b1, a, d, be, 1'b0, 1'b0, 0, 32'd0);
    endtask

    // Reset asserted while a transfer sits in WAIT.
    task automatic rst_mid(input bit w, input logic [31:0] a,
                           input logic [31:0] d);
        @(posedge clk); #1;
        bus.read       = !w;
        bus.write      = w;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = 4'hF;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rst_waitreq", {31'd0, bus.waitrequest}, 32'd1);
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        err_m = 0;
        @(posedge clk); #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        #1;
        check("rst_waitreq_idle", {31'd0, bus.waitrequest}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic clr();
        load(1, 32'h2402_0010);
        rd(BASE + 32'h4);
        rst_mid(1'b0, BASE + 32'h8, 32'd0);
    endtask

    task automatic abort(input bit w, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk); #1;
        bus.read       = !w;
        bus.write      = w;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = 4'hF;
        @(posedge clk); #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        err_m = 1;
        check("abort_err", {31'd0, err}, 32'd1);
    endtask

    function automatic logic [31:0] bad_addr();
        unique case ($urandom % 3)
            0: return BASE - 4 * $urandom_range(1, 16);
            1: return BASE + DEPTH * 4 + 4 * $urandom_range(0, 100);
            default: return BASE + ($urandom_range(0, DEPTH - 1) << 2)
                            + $urandom_range(1, 3);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          r;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 32'd0;
        bus.writedata  = 32'd0;
        bus.byteenable = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_waitreq", {31'd0, bus.waitrequest}, 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(i, $urandom);
        load(DEPTH + 1, 32'h2402_0010);
        rd(BASE + 32'h4);

        load(4, 32'h1122_3344);
        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'b0101);
        rd(BASE + 32'h10);
        wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000);
        rd(BASE + 32'h10);

        xfer(1'b0, 1'b1, BASE + 32'h14, 32'h5555_5555, 4'hF,
             1'b0, 1'b1, 5, 32'hAAAA_AAAA);
        rd(BASE + 32'h14);

        for (int k = 0; k < 150; k++) begin
            r = 1'($urandom);
            a = BASE + ($urandom_range(0, DEPTH - 1) << 2);
            xfer(r, !r, a, $urandom, 4'($urandom), 1'($urandom),
                 1'b0, 0, 32'd0);
            if ($urandom % 8 == 0) load($urandom_range(0, 255), $urandom);
        end

        clr();
        rd(BASE - 32'h4);
        clr();
        rd(BASE + DEPTH * 4);
        clr();
        rd(BASE + 32'h2);
        clr();
        wr(BASE + DEPTH * 4, 32'h0BAD_0BAD, 4'hF);
        rd(BASE);
        clr();
        wr(BASE + 32'h22, 32'h0BAD_0BAD, 4'hF);
        rd(BASE + 32'h20);
        clr();
        xfer(1'b1, 1'b1, BASE + 32'hC, 32'h0BAD_0BAD, 4'hF,
             1'b0, 1'b0, 0, 32'd0);
        rd(BASE + 32'hC);
        clr();
        abort(1'b0, BASE + 32'h18, 32'd0);
        rd(BASE + 32'h18);
        clr();
        abort(1'b1, BASE + 32'h18, 32'h0BAD_0BAD);
        rd(BASE + 32'h18);
        rst_mid(1'b1, BASE + 32'h1C, 32'h0BAD_0BAD);
        rd(BASE + 32'h1C);

        for (int k = 0; k < 100; k++) begin
            r = 1'($urandom);
            a = ($urandom % 4 == 0) ? bad_addr()
                                    : BASE + ($urandom_range(0, DEPTH - 1) << 2);
            if ($urandom % 10 == 0)
                xfer(1'b1, 1'b1, a, $urandom, 4'hF, 1'b0, 1'b0, 0, 32'd0);
            else
                xfer(r, !r, a, $urandom, 4'($urandom), 1'($urandom),
                     1'b0, 0, 32'd0);
            if ($urandom % 16 == 0) clr();
        end

        repeat (4) @(posedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
